// File: rtl/alu_mc.sv
// Multi-cycle ALU with valid/ready on both sides. Single-cycle ops resolve on the
// accept edge; variable shifts and multiply iterate one bit per cycle in BUSY.
module alu_mc #(
    parameter  int W   = 8,
    parameter  int Ops = 4,
    localparam int SW  = $clog2(W)
) (
    input  logic           Clk,
    input  logic           Reset,
    input  logic           InValid,
    output logic           InReady,
    input  logic [W-1:0]   InputA,
    input  logic [W-1:0]   InputB,
    input  logic [Ops-1:0] OP,
    output logic           OutValid,
    input  logic           OutReady,
    output logic [W-1:0]   Out,
    output logic           Zero,
    output logic           Parity,
    output logic           Odd,
    output logic           Carry
);

    localparam logic [Ops-1:0] OP_ADD  = Ops'(0);
    localparam logic [Ops-1:0] OP_LSH  = Ops'(1);
    localparam logic [Ops-1:0] OP_RSH  = Ops'(2);
    localparam logic [Ops-1:0] OP_AND  = Ops'(3);
    localparam logic [Ops-1:0] OP_OR   = Ops'(4);
    localparam logic [Ops-1:0] OP_NEG  = Ops'(5);
    localparam logic [Ops-1:0] OP_GEQ  = Ops'(6);
    localparam logic [Ops-1:0] OP_EQ   = Ops'(7);
    localparam logic [Ops-1:0] OP_NEQ  = Ops'(8);
    localparam logic [Ops-1:0] OP_SUB  = Ops'(9);
    localparam logic [Ops-1:0] OP_XOR  = Ops'(10);
    localparam logic [Ops-1:0] OP_LSHN = Ops'(11);
    localparam logic [Ops-1:0] OP_RSHN = Ops'(12);
    localparam logic [Ops-1:0] OP_ASR  = Ops'(13);
    localparam logic [Ops-1:0] OP_MUL  = Ops'(14);
    localparam logic [SW:0]    CNT_MUL = (SW+1)'(W);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t         r_state;
    state_t         w_next;
    logic           r_live;
    logic [W-1:0]   r_a;
    logic [Ops-1:0] r_op;
    logic [2*W-1:0] r_acc;
    logic [SW:0]    r_cnt;
    logic [W-1:0]   r_out;
    logic           r_zero;
    logic           r_parity;
    logic           r_odd;
    logic           r_carry;

    logic           w_accept;
    logic [SW-1:0]  w_n;
    logic           w_is_shn;
    logic           w_is_mul;
    logic           w_go_busy;
    logic           w_last;
    logic           w_ld;
    logic [W:0]     w_add;
    logic [W:0]     w_sum;
    logic [W-1:0]   w_sc_res;
    logic           w_sc_cy;
    logic [W-1:0]   w_it_a;
    logic [2*W-1:0] w_it_acc;
    logic           w_it_cy;
    logic [W-1:0]   w_res;
    logic           w_cy;

    assign w_accept  = InValid && InReady;
    assign w_n       = InputB[SW-1:0];
    assign w_is_shn  = (OP == OP_LSHN) || (OP == OP_RSHN) || (OP == OP_ASR);
    assign w_is_mul  = (OP == OP_MUL);
    assign w_go_busy = w_is_mul || (w_is_shn && (w_n != '0));
    assign w_last    = (r_cnt == (SW+1)'(1));
    assign w_ld      = (w_accept && !w_go_busy) || ((r_state == S_BUSY) && w_last);
    assign w_add     = {1'b0, InputA} + {1'b0, InputB};
    // Shift-add step: upper half accumulates A, multiplier bits drain out of the bottom
    assign w_sum     = {1'b0, r_acc[2*W-1:W]} + (r_acc[0] ? {1'b0, r_a} : '0);

    // ---------------- FSM ----------------
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_next = w_go_busy ? S_BUSY : S_DONE;
            S_BUSY: if (w_last)   w_next = S_DONE;
            S_DONE: if (OutReady) w_next = S_IDLE;
            default:              w_next = S_IDLE;
        endcase
    end

    // r_live holds InReady low until the first edge after reset release
    always_comb begin
        InReady  = (r_state == S_IDLE) && r_live;
        OutValid = (r_state == S_DONE);
    end

    // ---------------- single-cycle results ----------------
    always_comb begin
        w_sc_res = '0;
        w_sc_cy  = 1'b0;
        case (OP)
            OP_ADD:  begin w_sc_res = w_add[W-1:0]; w_sc_cy = w_add[W]; end
            OP_LSH:  begin w_sc_res = {InputA[W-2:0], 1'b0}; w_sc_cy = InputA[W-1]; end
            OP_RSH:  begin w_sc_res = {1'b0, InputA[W-1:1]}; w_sc_cy = InputA[0]; end
            OP_AND:  w_sc_res = InputA & InputB;
            OP_OR:   w_sc_res = InputA | InputB;
            OP_NEG:  w_sc_res = (~InputA) + W'(1);
            OP_GEQ:  w_sc_res = W'(InputA >= InputB);
            OP_EQ:   w_sc_res = W'(InputA == InputB);
            OP_NEQ:  w_sc_res = W'(InputA != InputB);
            OP_SUB:  begin w_sc_res = InputA - InputB; w_sc_cy = (InputA >= InputB); end
            OP_XOR:  w_sc_res = InputA ^ InputB;
            // only reached with n == 0: result is A, nothing shifted out
            OP_LSHN, OP_RSHN, OP_ASR: w_sc_res = InputA;
            default: w_sc_res = '0;
        endcase
    end

    // ---------------- one iteration of the multi-cycle ops ----------------
    always_comb begin
        w_it_a   = r_a;
        w_it_acc = r_acc;
        w_it_cy  = 1'b0;
        case (r_op)
            OP_LSHN: begin w_it_a = {r_a[W-2:0], 1'b0};  w_it_cy = r_a[W-1]; end
            OP_RSHN: begin w_it_a = {1'b0, r_a[W-1:1]};  w_it_cy = r_a[0];   end
            OP_ASR:  begin w_it_a = {r_a[W-1], r_a[W-1:1]}; w_it_cy = r_a[0]; end
            OP_MUL:  begin
                w_it_acc = {w_sum, r_acc[W-1:1]};
                w_it_cy  = |w_it_acc[2*W-1:W];
            end
            default: ;
        endcase
    end

    always_comb begin
        if (r_state == S_BUSY) begin
            w_res = (r_op == OP_MUL) ? w_it_acc[W-1:0] : w_it_a;
            w_cy  = w_it_cy;
        end else begin
            w_res = w_sc_res;
            w_cy  = w_sc_cy;
        end
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_live   <= 1'b0;
            r_a      <= '0;
            r_op     <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_out    <= '0;
            r_zero   <= 1'b0;
            r_parity <= 1'b0;
            r_odd    <= 1'b0;
            r_carry  <= 1'b0;
        end else begin
            r_live <= 1'b1;
            if (w_accept) begin
                r_a   <= InputA;
                r_op  <= OP;
                r_acc <= {{W{1'b0}}, InputB};
                r_cnt <= w_is_mul ? CNT_MUL : (w_is_shn ? {1'b0, w_n} : '0);
            end else if (r_state == S_BUSY) begin
                r_a   <= w_it_a;
                r_acc <= w_it_acc;
                r_cnt <= r_cnt - (SW+1)'(1);
            end
            if (w_ld) begin
                r_out    <= w_res;
                r_zero   <= (w_res == '0);
                r_parity <= ^w_res;
                r_odd    <= w_res[0];
                r_carry  <= w_cy;
            end
        end
    end

    assign Out    = r_out;
    assign Zero   = r_zero;
    assign Parity = r_parity;
    assign Odd    = r_odd;
    assign Carry  = r_carry;

endmodule

// File: tb/tb_alu_mc.sv
// Scoreboard bench for alu_mc (W=8): expectations are queued at issue time and
// popped when the result is presented.
module tb_alu_mc;

    localparam int W = 8;

    typedef struct {
        logic [7:0] res;
        logic       cy;
        int         lat;
    } exp_t;

    logic       Clk = 1'b0;
    logic       Reset = 1'b0;
    logic       InValid = 1'b0;
    logic       InReady;
    logic [7:0] InputA = '0;
    logic [7:0] InputB = '0;
    logic [3:0] OP = '0;
    logic       OutValid;
    logic       OutReady = 1'b0;
    logic [7:0] Out;
    logic       Zero, Parity, Odd, Carry;

    int   vectors = 0;
    int   miscompares = 0;
    exp_t sb[$];

    alu_mc #(.W(W), .Ops(4)) dut (
        .Clk(Clk), .Reset(Reset), .InValid(InValid), .InReady(InReady),
        .InputA(InputA), .InputB(InputB), .OP(OP),
        .OutValid(OutValid), .OutReady(OutReady), .Out(Out),
        .Zero(Zero), .Parity(Parity), .Odd(Odd), .Carry(Carry)
    );

    always #5 Clk = ~Clk;

    function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
        exp_t e;
        logic [8:0] s;
        logic [15:0] p;
        logic signed [7:0] sa;
        int n;
        n = int'(b[2:0]);
        sa = a;
        e.cy = 1'b0;
        e.lat = 1;
        e.res = 8'h00;
        case (op)
            4'd0:  begin s = {1'b0, a} + {1'b0, b}; e.res = s[7:0]; e.cy = s[8]; end
            4'd1:  begin e.res = a << 1; e.cy = a[7]; end
            4'd2:  begin e.res = a >> 1; e.cy = a[0]; end
            4'd3:  e.res = a & b;
            4'd4:  e.res = a | b;
            4'd5:  e.res = 8'(-a);
            4'd6:  e.res = (a >= b) ? 8'h01 : 8'h00;
            4'd7:  e.res = (a == b) ? 8'h01 : 8'h00;
            4'd8:  e.res = (a != b) ? 8'h01 : 8'h00;
            4'd9:  begin e.res = a - b; e.cy = (a >= b); end
            4'd10: e.res = a ^ b;
            4'd11: begin e.res = a << n; e.cy = (n == 0) ? 1'b0 : a[8-n]; e.lat = 1 + n; end
            4'd12: begin e.res = a >> n; e.cy = (n == 0) ? 1'b0 : a[n-1]; e.lat = 1 + n; end
            4'd13: begin e.res = sa >>> n; e.cy = (n == 0) ? 1'b0 : a[n-1]; e.lat = 1 + n; end
            4'd14: begin p = {8'h00, a} * {8'h00, b}; e.res = p[7:0]; e.cy = |p[15:8]; e.lat = 1 + W; end
            default: e.res = 8'h00;
        endcase
        return e;
    endfunction

    // Issue one op from IDLE and wait (bounded) until OutValid; edges counts from the accept edge.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op, output int edges);
        @(negedge Clk);
        InputA = a; InputB = b; OP = op; InValid = 1'b1;
        sb.push_back(model(a, b, op));
        @(posedge Clk); #1 InValid = 1'b0;
        edges = 1;
        @(negedge Clk);
        while (!OutValid && edges < 64) begin
            @(posedge Clk); edges++; @(negedge Clk);
        end
    endtask

    task automatic consume();
        @(negedge Clk); OutReady = 1'b1;
        @(posedge Clk); #1 OutReady = 1'b0;
    endtask

    task automatic test_reset();
        Reset = 1'b0;
        #12;
        vectors++;
        if ({OutValid, Out, Zero, Parity, Odd, Carry} !== 13'h0) begin
            miscompares++;
            $display("FAIL reset_state: got valid=%b out=%h flags=%b%b%b%b want all 0",
                     OutValid, Out, Zero, Parity, Odd, Carry);
        end
        @(negedge Clk); Reset = 1'b1;
        @(posedge Clk); @(negedge Clk);
        vectors++;
        if (InReady !== 1'b1 || OutValid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_release: got inready=%b outvalid=%b want 1/0", InReady, OutValid);
        end
    endtask

    task automatic test_single();
        logic [19:0] tv [10] = '{
            {4'd0, 8'hF0, 8'h20}, {4'd4, 8'h0C, 8'h03}, {4'd9, 8'h05, 8'h80}, {4'd6, 8'h05, 8'h80},
            {4'd7, 8'h3C, 8'h3C}, {4'd5, 8'h01, 8'h00}, {4'd10, 8'hA5, 8'h0F}, {4'd3, 8'hF3, 8'h3C},
            {4'd1, 8'h81, 8'h00}, {4'd2, 8'h81, 8'h00}};
        exp_t e;
        int edges;
        foreach (tv[i]) begin
            run_op(tv[i][15:8], tv[i][7:0], tv[i][19:16], edges);
            e = sb.pop_front();
            vectors++;
            if ({Out, Carry, Zero, Parity, Odd} !== {e.res, e.cy, e.res == 8'h00, ^e.res, e.res[0]}) begin
                miscompares++;
                $display("FAIL single op=%0d: got out=%h czpo=%b%b%b%b want out=%h c=%b",
                         tv[i][19:16], Out, Carry, Zero, Parity, Odd, e.res, e.cy);
            end
            vectors++;
            if (edges !== e.lat) begin
                miscompares++;
                $display("FAIL single_lat op=%0d: got %0d want %0d", tv[i][19:16], edges, e.lat);
            end
            consume();
        end
    endtask

    task automatic test_shift();
        logic [19:0] tv [6] = '{
            {4'd11, 8'h81, 8'h03}, {4'd13, 8'h90, 8'h02}, {4'd12, 8'hB7, 8'h00},
            {4'd12, 8'hF1, 8'h07}, {4'd13, 8'h7F, 8'h05}, {4'd11, 8'h40, 8'h01}};
        exp_t e;
        int edges;
        foreach (tv[i]) begin
            run_op(tv[i][15:8], tv[i][7:0], tv[i][19:16], edges);
            e = sb.pop_front();
            vectors++;
            if ({Out, Carry, Zero, Parity, Odd} !== {e.res, e.cy, e.res == 8'h00, ^e.res, e.res[0]}) begin
                miscompares++;
                $display("FAIL shift op=%0d n=%0d: got out=%h czpo=%b%b%b%b want out=%h c=%b",
                         tv[i][19:16], tv[i][2:0], Out, Carry, Zero, Parity, Odd, e.res, e.cy);
            end
            vectors++;
            if (edges !== e.lat) begin
                miscompares++;
                $display("FAIL shift_lat op=%0d: got %0d want %0d", tv[i][19:16], edges, e.lat);
            end
            consume();
        end
    endtask

    task automatic test_mul();
        logic [15:0] tv [4] = '{{8'd13, 8'd11}, {8'h20, 8'h10}, {8'hFF, 8'hFF}, {8'h00, 8'h7B}};
        exp_t e;
        int edges;
        foreach (tv[i]) begin
            run_op(tv[i][15:8], tv[i][7:0], 4'd14, edges);
            e = sb.pop_front();
            vectors++;
            if ({Out, Carry, Zero, Parity, Odd} !== {e.res, e.cy, e.res == 8'h00, ^e.res, e.res[0]}) begin
                miscompares++;
                $display("FAIL mul %h*%h: got out=%h czpo=%b%b%b%b want out=%h c=%b",
                         tv[i][15:8], tv[i][7:0], Out, Carry, Zero, Parity, Odd, e.res, e.cy);
            end
            vectors++;
            if (edges !== e.lat) begin
                miscompares++;
                $display("FAIL mul_lat: got %0d want %0d", edges, e.lat);
            end
            consume();
        end
    endtask

    task automatic test_random();
        exp_t e;
        int edges;
        logic [3:0] op;
        for (int i = 0; i < 30; i++) begin
            op = 4'($urandom_range(0, 15));
            run_op(8'($urandom), 8'($urandom), op, edges);
            e = sb.pop_front();
            vectors++;
            if ({Out, Carry, Zero, Parity, Odd} !== {e.res, e.cy, e.res == 8'h00, ^e.res, e.res[0]} ||
                edges !== e.lat) begin
                miscompares++;
                $display("FAIL random op=%0d: got out=%h c=%b lat=%0d want out=%h c=%b lat=%0d",
                         op, Out, Carry, edges, e.res, e.cy, e.lat);
            end
            consume();
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int edges;
        run_op(8'hF0, 8'h20, 4'd0, edges);
        e = sb.pop_front();
        vectors++;
        if ({Out, Carry} !== {e.res, e.cy} || edges !== 1) begin
            miscompares++;
            $display("FAIL bp_add: got out=%h c=%b lat=%0d want out=%h c=%b lat=1", Out, Carry, edges, e.res, e.cy);
        end
        // A new request is held pending while the result is not consumed.
        @(negedge Clk);
        InputA = 8'h55; InputB = 8'h0F; OP = 4'd10; InValid = 1'b1;
        sb.push_back(model(8'h55, 8'h0F, 4'd10));
        for (int c = 0; c < 5; c++) begin
            @(posedge Clk); @(negedge Clk);
            vectors++;
            if ({OutValid, InReady, Out, Carry, Zero, Parity, Odd} !==
                {1'b1, 1'b0, e.res, e.cy, e.res == 8'h00, ^e.res, e.res[0]}) begin
                miscompares++;
                $display("FAIL bp_hold cyc=%0d: got v=%b r=%b out=%h czpo=%b%b%b%b want v=1 r=0 out=%h",
                         c, OutValid, InReady, Out, Carry, Zero, Parity, Odd, e.res);
            end
        end
        OutReady = 1'b1;
        @(posedge Clk); #1 OutReady = 1'b0;
        @(negedge Clk);
        vectors++;
        if (OutValid !== 1'b0 || InReady !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_idle: got outvalid=%b inready=%b want 0/1", OutValid, InReady);
        end
        @(posedge Clk); #1 InValid = 1'b0;
        edges = 1;
        @(negedge Clk);
        while (!OutValid && edges < 64) begin
            @(posedge Clk); edges++; @(negedge Clk);
        end
        e = sb.pop_front();
        vectors++;
        if ({Out, Carry, Zero} !== {e.res, e.cy, e.res == 8'h00} || edges !== 1) begin
            miscompares++;
            $display("FAIL bp_next: got out=%h c=%b lat=%0d want out=%h c=%b lat=1", Out, Carry, edges, e.res, e.cy);
        end
        consume();
    endtask

    task automatic test_reset_mid_mul();
        exp_t e;
        int edges;
        run_op(8'h0F, 8'h01, 4'd0, edges);
        e = sb.pop_front();
        vectors++;
        if (Out !== e.res) begin
            miscompares++;
            $display("FAIL rst_pre: got out=%h want %h", Out, e.res);
        end
        consume();
        @(negedge Clk);
        InputA = 8'd13; InputB = 8'd11; OP = 4'd14; InValid = 1'b1;
        @(posedge Clk); #1 InValid = 1'b0;
        repeat (3) @(posedge Clk);
        #1 Reset = 1'b0;
        #1;
        vectors++;
        if ({OutValid, Out, Zero, Parity, Odd, Carry} !== 13'h0) begin
            miscompares++;
            $display("FAIL rst_mid_mul: got valid=%b out=%h flags=%b%b%b%b want all 0",
                     OutValid, Out, Zero, Parity, Odd, Carry);
        end
        repeat (2) @(negedge Clk);
        Reset = 1'b1;
        @(posedge Clk); @(negedge Clk);
        vectors++;
        if (InReady !== 1'b1 || OutValid !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_after: got inready=%b outvalid=%b want 1/0", InReady, OutValid);
        end
        run_op(8'h01, 8'h01, 4'd0, edges);
        e = sb.pop_front();
        vectors++;
        if (Out !== 8'h02 || Out !== e.res || edges !== 1) begin
            miscompares++;
            $display("FAIL rst_fresh_add: got out=%h lat=%0d want 02 lat=1", Out, edges);
        end
        consume();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_shift();
        test_mul();
        test_back_to_back();
        test_random();
        test_reset_mid_mul();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/alu_mc.md
Name: alu_mc

Overview:
Parametrised, multi-cycle successor to the combinational datapath ALU, sitting between the register file read ports and the writeback mux. It adds a valid/ready handshake on both sides and iterative variable shifts and multiply, one bit per cycle. Result and status flags are registered together and held until consumed. The original single-cycle opcodes keep their codes, and OR is now strictly bitwise.

Parameters:
W, 8, datapath width (W >= 4, power of two)
Ops, 4, opcode width
SW, $clog2(W), shift-amount width; derived, not overridden

Ports:
Clk  input  1  clock, rising edge
Reset  input  1  asynchronous, active-low reset
InValid  input  1  operands/opcode valid
InReady  output  1  block can accept an operation
InputA  input  W  operand A
InputB  input  W  operand B; shift ops use InputB[SW-1:0] as the amount
OP  input  Ops  opcode
OutValid  output  1  result valid
OutReady  input  1  consumer accepts result
Out  output  W  registered result
Zero  output  1  Out == 0
Parity  output  1  ^Out
Odd  output  1  Out[0]
Carry  output  1  op-specific carry (see below)

Behaviour:
- Opcodes and results (all unsigned):
  - 0 ADD: A+B; Carry = carry out.
  - 1 LSH: A<<1; Carry = A[W-1].
  - 2 RSH: A>>1; Carry = A[0].
  - 3 AND: A&B.
  - 4 OR: A|B.
  - 5 NEG: ~A+1.
  - 6 GEQ: A>=B ? 1 : 0.
  - 7 EQ: A==B ? 1 : 0.
  - 8 NEQ: A!=B ? 1 : 0.
  - 9 SUB: A-B; Carry = (A>=B).
  - 10 XOR: A^B.
  - 11 LSHN: logical left shift by n = B[SW-1:0].
  - 12 RSHN: logical right shift by n.
  - 13 ASR: arithmetic right shift by n.
  - 14 MUL: low W bits of A*B; Carry = (high W bits != 0).
  - 15 NOP: Out = 0.
  - Shift Carry = last bit shifted out; 0 when n = 0.
  - Carry = 0 for AND/OR/NEG/GEQ/EQ/NEQ/XOR/NOP.
- Flags: Zero/Parity/Odd are computed from the final result. All four flags register on the same edge as Out.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: InReady = 1. Accept when InValid && InReady at a rising edge; latch A, B, OP.
    - Single-cycle ops, and shift ops with n = 0: go to DONE.
    - Shift ops with n > 0: go to BUSY, count = n.
    - MUL: go to BUSY, count = W (shift-add, one partial product per cycle).
  - BUSY: InReady = 0. One iteration per cycle, count decrements. On the edge where count reaches 0, load Out/flags and go to DONE.
  - DONE: OutValid = 1, InReady = 0. On OutReady high at an edge, go to IDLE (OutValid drops next cycle).
- Latency, counted in edges after the accept edge at which OutValid is first high:
  - single-cycle ops and n = 0 shifts: 1
  - shifts: 1+n
  - MUL: 1+W
- Throughput: no overlap. The next accept is at the earliest on the edge after the OutReady handshake.
- Out and flags are stable throughout DONE, regardless of input changes. Inputs are ignored outside IDLE.
- OutReady while not in DONE is ignored. InValid while InReady = 0 is ignored; the producer must hold it.
- Reset low (asynchronous, any state, including mid-BUSY):
  - state = IDLE; OutValid = 0; Out = 0; all flags 0; count = 0.
  - InReady = 1 from the first edge after Reset deasserts.
- Width rules: intermediate adds are W+1 bits; the MUL accumulator is 2W bits. Only Out[W-1:0] is exposed.

Test Plan:
- W=8, ADD A=0xF0 B=0x20 -> 1 cycle: Out=0x10, Carry=1, Zero=0, Parity=1, Odd=0. OR A=0x0C B=0x03 -> Out=0x0F (not 0x01).
- LSHN A=0x81 B=3 -> OutValid 4 edges after accept, Out=0x08, Carry=0. ASR A=0x90 B=2 -> Out=0xE4, Carry=0. RSHN with B=0 -> 1-cycle latency, Out=A, Carry=0.
- MUL A=13 B=11 -> OutValid 9 edges after accept, Out=0x8F, Carry=0. MUL A=0x20 B=0x10 -> Out=0x00, Carry=1, Zero=1.
- SUB A=0x05 B=0x80 -> Out=0x85, Carry=0. GEQ on the same operands -> Out=0x00. EQ A=B=0x3C -> Out=0x01, Odd=1.
- Backpressure: hold OutReady=0 for 5 cycles after ADD completes -> Out and flags stable, InReady=0, a new InValid is not accepted. Raise OutReady -> IDLE next edge, then the new op is accepted.
- Assert Reset low 3 cycles into a MUL -> outputs clear immediately. After release: InReady=1, OutValid=0, and a fresh ADD 1+1 -> Out=0x02.
